axil_mem_slave: RTL

//  Parametrised AXI4-Lite memory slave: byte-addressed RAM behind independent write (AW/W/B)
//  and read (AR/R) channels, with byte strobes, alignment and range checking, and error responses.

---
 rtl/axil_pkg.sv | 34 +++
 rtl/axil_bram_be.sv | 29 ++
 rtl/axil_mem_slave.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared types and the address checker for the AXI4-Lite memory slave.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_e;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_W = 2'd2,
    W_RESP   = 2'd3
  } axil_wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } axil_rstate_e;

  // Out-of-range beats misalignment so a stray high address is reported as DECERR.
  function automatic axil_resp_e axil_addr_chk(input logic [63:0] addr,
                                               input int unsigned addr_lsb,
                                               input logic [63:0] mem_bytes);
    logic [63:0] mask;
    mask = (64'd1 << addr_lsb) - 64'd1;
    if (addr >= mem_bytes) return DECERR;
    if ((addr & mask) != 64'd0) return SLVERR;
    return OKAY;
  endfunction

endpackage

// File: rtl/axil_bram_be.sv
// Simple dual-port RAM: one byte-enabled write port, one synchronous read port.
module axil_bram_be #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [IDX_W-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    re,
  input  logic [IDX_W-1:0]        raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read and write on the same edge: the read samples the old word.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/axil_mem_slave.sv
// AXI4-Lite memory slave with independent write/read FSMs and address checking.
// Define AXIL_MEM_RO_EN to make [0, RO_BYTES) reject writes with SLVERR.
module axil_mem_slave
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 4096,
  parameter int RO_BYTES   = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [1:0]              wstate_dbg,
  output logic                    rstate_dbg
);

  // Handshakes: a transfer happens on a posedge where valid && ready are both high;
  // valid, once raised by a source, holds with its payload until that transfer.
  localparam int NB       = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(NB);
  localparam int DEPTH    = MEM_BYTES / NB;
  localparam int IDX_W    = $clog2(DEPTH);
`ifdef AXIL_MEM_RO_EN
  localparam bit RO_EN = 1'b1;
`else
  localparam bit RO_EN = 1'b0;
`endif

  axil_wstate_e wstate_q, wstate_d;
  axil_rstate_e rstate_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [NB-1:0]         w_strb_q;
  axil_resp_e            bresp_q, rresp_q;
  logic                  rd_ok_q;

  logic                  commit, cap_a, cap_w;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_data;
  logic [NB-1:0]         c_strb;
  axil_resp_e            c_resp, ar_resp;
  logic                  ar_fire, ram_we, ram_re;
  logic [DATA_WIDTH-1:0] ram_dout;

  always_comb begin
    wstate_d = wstate_q;
    commit   = 1'b0;
    cap_a    = 1'b0;
    cap_w    = 1'b0;
    c_addr   = awaddr;
    c_data   = wdata;
    c_strb   = wstrb;
    case (wstate_q)
      W_IDLE: begin
        if (awvalid && wvalid) commit = 1'b1;
        else if (awvalid) begin
          cap_a    = 1'b1;
          wstate_d = W_HAVE_A;
        end else if (wvalid) begin
          cap_w    = 1'b1;
          wstate_d = W_HAVE_W;
        end
      end
      W_HAVE_A: begin
        c_addr = aw_addr_q;
        commit = wvalid;
      end
      W_HAVE_W: begin
        c_data = w_data_q;
        c_strb = w_strb_q;
        commit = awvalid;
      end
      W_RESP: if (bready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
    if (commit) wstate_d = W_RESP;

    c_resp = axil_addr_chk(64'(c_addr), ADDR_LSB, 64'(MEM_BYTES));
    if (RO_EN && c_resp == OKAY && 64'(c_addr) < 64'(RO_BYTES)) c_resp = SLVERR;
    ram_we = commit && (c_resp == OKAY);

    ar_fire = (rstate_q == R_IDLE) && arvalid;
    ar_resp = axil_addr_chk(64'(araddr), ADDR_LSB, 64'(MEM_BYTES));
    ram_re  = ar_fire && (ar_resp == OKAY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= OKAY;
      rresp_q   <= OKAY;
      rd_ok_q   <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      if (cap_a) aw_addr_q <= awaddr;
      if (cap_w) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (commit) bresp_q <= c_resp;
      if (ar_fire) begin
        rstate_q <= R_RESP;
        rresp_q  <= ar_resp;
        rd_ok_q  <= (ar_resp == OKAY);
      end else if (rstate_q == R_RESP && rready) begin
        rstate_q <= R_IDLE;
      end
    end
  end

  axil_bram_be #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .be   (c_strb),
    .waddr(IDX_W'(c_addr >> ADDR_LSB)),
    .wdata(c_data),
    .re   (ram_re),
    .raddr(IDX_W'(araddr >> ADDR_LSB)),
    .rdata(ram_dout)
  );

  // Readies and valids decode straight from the state flops.
  assign awready    = (wstate_q == W_IDLE) || (wstate_q == W_HAVE_W);
  assign wready     = (wstate_q == W_IDLE) || (wstate_q == W_HAVE_A);
  assign bvalid     = (wstate_q == W_RESP);
  assign bresp      = bresp_q;
  assign arready    = (rstate_q == R_IDLE);
  assign rvalid     = (rstate_q == R_RESP);
  assign rresp      = rresp_q;
  assign rdata      = rd_ok_q ? ram_dout : '0;
  assign wstate_dbg = wstate_q;
  assign rstate_dbg = rstate_q;

endmodule
